instruction_fetch: RTL and testbench

- Fetch stage directly upstream of Immediate_Generation and the decode/control logic.
- Holds the PC, issues one word-aligned request at a time to instruction memory over a req/ready + valid handshake, and presents the fetched word as Instruction to the decode stage (Immediate_Generation Input).
- Supports downstream stall through a one-entry skid buffer, and branch/jump redirect with kill of any in-flight fetch.

---
 rtl/instruction_fetch.sv | 131 +++++++++++++
 tb/tb_instruction_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, one-outstanding imem handshake, one-entry skid buffer and redirect with kill.
// Optional macro FETCH_COUNT_EN adds the Fetch_Count output counting consumed instructions.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ready,
    input  logic        Imem_Valid,
    input  logic [31:0] Imem_Data,
    output logic        Instr_Valid,
    output logic [31:0] Instruction,
    output logic [31:0] Instr_PC
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0] Fetch_Count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic        kill;
    logic        skid_valid;
    logic [31:0] skid_data;
    logic [31:0] skid_pc;

    logic        req;
    logic        handshake;
    logic        response;
    logic        deliver;
    logic        consume;

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        req        = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                req = !skid_valid;
                if (req && Imem_Ready) state_next = WAIT;
            end
            WAIT: if (Imem_Valid) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    assign Imem_Req  = req;
    assign Imem_Addr = pc;
    assign handshake = req && Imem_Ready;
    assign response  = (state == WAIT) && Imem_Valid;
    assign deliver   = response && !kill;
    assign consume   = Instr_Valid && !Stall;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc          <= RESET_PC;
            pending_pc  <= 32'h0;
            kill        <= 1'b0;
            skid_valid  <= 1'b0;
            skid_data   <= 32'h0;
            skid_pc     <= 32'h0;
            Instr_Valid <= 1'b0;
            Instruction <= NOP_WORD;
            Instr_PC    <= 32'h0;
        end else begin
            if (handshake) begin
                pending_pc <= pc;
                pc         <= pc + 32'd4;
            end
            if (Branch_Taken) begin
                pc          <= {Branch_Target[31:2], 2'b00};
                Instr_Valid <= 1'b0;
                Instruction <= NOP_WORD;
                skid_valid  <= 1'b0;
                // A response arriving with the redirect is simply dropped; otherwise any live request is killed.
                if (response)                           kill <= 1'b0;
                else if ((state == WAIT) || handshake) kill <= 1'b1;
            end else begin
                if (response && kill) kill <= 1'b0;
                if (deliver) begin
                    if (!Instr_Valid || consume) begin
                        Instr_Valid <= 1'b1;
                        Instruction <= Imem_Data;
                        Instr_PC    <= pending_pc;
                    end else begin
                        skid_valid <= 1'b1;
                        skid_data  <= Imem_Data;
                        skid_pc    <= pending_pc;
                    end
                end else if (consume) begin
                    if (skid_valid) begin
                        Instruction <= skid_data;
                        Instr_PC    <= skid_pc;
                        skid_valid  <= 1'b0;
                    end else begin
                        Instr_Valid <= 1'b0;
                        Instruction <= NOP_WORD;
                    end
                end
            end
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge Clock) begin
        if (Reset)        Fetch_Count <= 32'h0;
        else if (consume) Fetch_Count <= Fetch_Count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, zero-wait stream, stall/skid, kill, simultaneous events, reset mid-WAIT.
// The memory responder lives in tick(): an accepted request returns Addr|0xAB000000 one cycle later.
module tb_instruction_fetch;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [31:0] Branch_Target = 32'h0;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ready = 1'b1;
    logic        Imem_Valid = 1'b0;
    logic [31:0] Imem_Data = 32'h0;
    logic        Instr_Valid;
    logic [31:0] Instruction;
    logic [31:0] Instr_PC;
`ifdef FETCH_COUNT_EN
    logic [31:0] Fetch_Count;
`endif

    int checks = 0;
    int errors = 0;
    logic mem_auto = 1'b1;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hAB00_0000;

    instruction_fetch dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Stall         (Stall),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Imem_Req      (Imem_Req),
        .Imem_Addr     (Imem_Addr),
        .Imem_Ready    (Imem_Ready),
        .Imem_Valid    (Imem_Valid),
        .Imem_Data     (Imem_Data),
        .Instr_Valid   (Instr_Valid),
        .Instruction   (Instruction),
        .Instr_PC      (Instr_PC)
`ifdef FETCH_COUNT_EN
        ,
        .Fetch_Count   (Fetch_Count)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        logic        acc;
        logic [31:0] addr;
        acc  = (Imem_Req === 1'b1) && (Imem_Ready === 1'b1);
        addr = Imem_Addr;
        @(posedge Clock);
        #1;
        if (mem_auto) begin
            Imem_Valid = acc;
            Imem_Data  = acc ? (addr | TAG) : 32'h0;
        end
    endtask

    initial begin
        // Reset held for two cycles
        tick(); tick();
        check("rst_req",   32'(Imem_Req), 32'h0);
        check("rst_valid", 32'(Instr_Valid), 32'h0);
        check("rst_instr", Instruction, NOP);
        check("rst_pc",    Instr_PC, 32'h0);
`ifdef FETCH_COUNT_EN
        check("rst_count", Fetch_Count, 32'h0);
`endif
        Reset = 1'b0;

        // Zero-wait stream
        tick();                                   // IDLE -> REQ
        check("first_req",  32'(Imem_Req), 32'h1);
        check("first_addr", Imem_Addr, 32'h0);
        tick();                                   // accept 0x0
        check("wait_req",   32'(Imem_Req), 32'h0);
        check("wait_valid", 32'(Instr_Valid), 32'h0);
        tick();                                   // deliver 0x0
        check("s0_valid", 32'(Instr_Valid), 32'h1);
        check("s0_instr", Instruction, 32'hAB00_0000);
        check("s0_pc",    Instr_PC, 32'h0);
        check("s1_addr",  Imem_Addr, 32'h4);
        tick();
        check("s0_fall_valid", 32'(Instr_Valid), 32'h0);
        check("s0_fall_instr", Instruction, NOP);
        tick();
        check("s1_valid", 32'(Instr_Valid), 32'h1);
        check("s1_instr", Instruction, 32'hAB00_0004);
        check("s1_pc",    Instr_PC, 32'h4);
        tick();
        check("s1_fall", 32'(Instr_Valid), 32'h0);
        tick();
        check("s2_valid", 32'(Instr_Valid), 32'h1);
        check("s2_instr", Instruction, 32'hAB00_0008);
        check("s2_pc",    Instr_PC, 32'h8);
        check("s3_addr",  Imem_Addr, 32'hC);

        // Stall for 6 cycles while 0x8 is held; 0xC lands in the skid
        Stall = 1'b1;
        tick();
        check("stall_hold_instr", Instruction, 32'hAB00_0008);
        check("stall_hold_valid", 32'(Instr_Valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("skid_full_no_req", 32'(Imem_Req), 32'h0);
            check("stall_hold_pc",    Instr_PC, 32'h8);
        end
        Stall = 1'b0;
        tick();
        check("skid_out_valid", 32'(Instr_Valid), 32'h1);
        check("skid_out_instr", Instruction, 32'hAB00_000C);
        check("skid_out_pc",    Instr_PC, 32'hC);
        check("post_skid_req",  32'(Imem_Req), 32'h1);
        check("post_skid_addr", Imem_Addr, 32'h10);

        // Kill: redirect while waiting for 0x10
        mem_auto   = 1'b0;
        Imem_Valid = 1'b0;
        tick();                                   // accept 0x10, 0xC consumed
        check("kill_wait_valid", 32'(Instr_Valid), 32'h0);
        Branch_Taken  = 1'b1;
        Branch_Target = 32'h0000_0103;
        tick();
        Branch_Taken = 1'b0;
        check("kill_still_wait", 32'(Imem_Req), 32'h0);
        Imem_Valid = 1'b1;
        Imem_Data  = 32'hAB00_0010;
        tick();                                   // killed response dropped
        Imem_Valid = 1'b0;
        check("kill_drop_valid", 32'(Instr_Valid), 32'h0);
        check("kill_req",        32'(Imem_Req), 32'h1);
        check("kill_new_addr",   Imem_Addr, 32'h100);
        mem_auto = 1'b1;
        tick();
        tick();
        check("tgt_valid", 32'(Instr_Valid), 32'h1);
        check("tgt_pc",    Instr_PC, 32'h100);
        check("tgt_instr", Instruction, 32'hAB00_0100);

        // Branch + Stall with a held instruction (and a handshake in the same cycle)
        Stall         = 1'b1;
        Branch_Taken  = 1'b1;
        Branch_Target = 32'h0000_0200;
        tick();
        Stall        = 1'b0;
        Branch_Taken = 1'b0;
        check("br_stall_valid", 32'(Instr_Valid), 32'h0);
        check("br_stall_instr", Instruction, NOP);
        tick();                                   // killed 0x104 response dropped
        check("br_hs_drop", 32'(Instr_Valid), 32'h0);
        check("br_hs_addr", Imem_Addr, 32'h200);
        tick();                                   // accept 0x200, response now on the bus
        Branch_Taken  = 1'b1;
        Branch_Target = 32'h0000_0300;
        tick();                                   // branch with Imem_Valid: dropped, no kill
        Branch_Taken = 1'b0;
        check("br_val_drop", 32'(Instr_Valid), 32'h0);
        check("br_val_req",  32'(Imem_Req), 32'h1);
        check("br_val_addr", Imem_Addr, 32'h300);
        tick();
        tick();
        check("no_kill_valid", 32'(Instr_Valid), 32'h1);
        check("no_kill_pc",    Instr_PC, 32'h300);
        check("no_kill_instr", Instruction, 32'hAB00_0300);

        // Reset mid-WAIT, then a late response
        mem_auto   = 1'b0;
        Imem_Valid = 1'b0;
        tick();                                   // accept 0x304, consume 0x300
`ifdef FETCH_COUNT_EN
        check("count_before_rst", Fetch_Count, 32'd5);
`endif
        Reset = 1'b1;
        tick();
        Reset      = 1'b0;
        Imem_Valid = 1'b1;
        Imem_Data  = 32'hDEAD_BEEF;
        check("midrst_valid", 32'(Instr_Valid), 32'h0);
        check("midrst_pc",    Instr_PC, 32'h0);
`ifdef FETCH_COUNT_EN
        check("count_after_rst", Fetch_Count, 32'h0);
`endif
        tick();                                   // late valid seen in IDLE
        check("late_idle_valid", 32'(Instr_Valid), 32'h0);
        check("late_req",        32'(Imem_Req), 32'h1);
        check("late_addr",       Imem_Addr, 32'h0);
        Imem_Ready = 1'b0;
        tick();                                   // late valid seen in REQ, no acceptance
        check("late_req_valid", 32'(Instr_Valid), 32'h0);
        check("addr_stable",    Imem_Addr, 32'h0);
        Imem_Valid = 1'b0;
        Imem_Ready = 1'b1;
        mem_auto   = 1'b1;
        tick();
        tick();
        check("restart_valid", 32'(Instr_Valid), 32'h1);
        check("restart_pc",    Instr_PC, 32'h0);
        check("restart_instr", Instruction, 32'hAB00_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
